// File: rtl/mac_kernel_sequencer_pkg.sv
// Shared constants and state encoding for the 3x3 kernel MAC sequencer.
// The accumulator width is derived here so every user agrees on it.
package mac_kernel_sequencer_pkg;

    localparam int TAPS = 9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Nine full-scale products need 2*DATA_W + ceil(log2(9)) bits.
    function automatic int acc_width(input int data_w);
        return 2 * data_w + 4;
    endfunction

endpackage

// File: rtl/mac_kernel_sequencer_if.sv
// Window-in / result-out handshake bundle of the kernel sequencer.
// master = upstream window stage plus downstream writer, slave = sequencer.
interface mac_kernel_sequencer_if #(
    parameter int DATA_W = 8
);
    import mac_kernel_sequencer_pkg::*;

    localparam int ACC_W = acc_width(DATA_W);

    logic                   In_valid_i;
    logic                   In_ready_o;
    logic [TAPS*DATA_W-1:0] Pixels_i;
    logic [TAPS*DATA_W-1:0] Coefs_i;
    logic [TAPS-1:0]        Signs_i;
    logic                   Out_valid_o;
    logic                   Out_ready_i;
    logic [ACC_W-1:0]       Magnitude_o;
    logic [DATA_W-1:0]      Pixel_o;
    logic                   Busy_o;

    modport master (
        output In_valid_i, Pixels_i, Coefs_i, Signs_i, Out_ready_i,
        input  In_ready_o, Out_valid_o, Magnitude_o, Pixel_o, Busy_o
    );

    modport slave (
        input  In_valid_i, Pixels_i, Coefs_i, Signs_i, Out_ready_i,
        output In_ready_o, Out_valid_o, Magnitude_o, Pixel_o, Busy_o
    );

endinterface

// File: rtl/mac_kernel_sequencer_mac.sv
// Combinational multiply-accumulate: Result_o = Accum_i + Mult1_i * Mult2_i.
// Result_o carries one extra bit so the sum can never wrap.
module Mac #(
    parameter int MULT_SIZE  = 8,
    parameter int ACCUM_SIZE = 20
) (
    input  logic [MULT_SIZE-1:0]  Mult1_i,
    input  logic [MULT_SIZE-1:0]  Mult2_i,
    input  logic [ACCUM_SIZE-1:0] Accum_i,
    output logic [ACCUM_SIZE:0]   Result_o
);

    logic [2*MULT_SIZE-1:0] w_product;

    assign w_product = (2*MULT_SIZE)'(Mult1_i) * (2*MULT_SIZE)'(Mult2_i);
    assign Result_o  = (ACCUM_SIZE+1)'(Accum_i) + (ACCUM_SIZE+1)'(w_product);

endmodule

// File: rtl/mac_kernel_sequencer.sv
// Walks one shared Mac over the nine taps of a 3x3 window, keeping separate
// positive/negative accumulators, and presents |pos - neg| raw and saturated.
module mac_kernel_sequencer
    import mac_kernel_sequencer_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                  Clk_i,
    input  logic                  Rst_n_i,
    mac_kernel_sequencer_if.slave io_bus
);

    localparam int ACC_W = acc_width(DATA_W);
    localparam int IDX_W = 4;

    state_t                 r_state;
    state_t                 w_next_state;
    logic [TAPS*DATA_W-1:0] r_pixels;
    logic [TAPS*DATA_W-1:0] r_coefs;
    logic [TAPS-1:0]        r_signs;
    logic [ACC_W-1:0]       r_acc_pos;
    logic [ACC_W-1:0]       r_acc_neg;
    logic [IDX_W-1:0]       r_idx;

    logic                   w_accept;
    logic                   w_last;
    logic [DATA_W-1:0]      w_pix;
    logic [DATA_W-1:0]      w_coef;
    logic                   w_sign;
    logic [ACC_W-1:0]       w_acc_sel;
    logic [ACC_W:0]         w_result;
    logic                   w_unused_carry;
    logic [ACC_W-1:0]       w_magnitude;

    always_ff @(posedge Clk_i or negedge Rst_n_i) begin
        if (!Rst_n_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    assign w_last = (r_idx == IDX_W'(TAPS - 1));

    always_comb begin
        w_next_state       = r_state;
        w_accept           = 1'b0;
        io_bus.In_ready_o  = 1'b0;
        io_bus.Out_valid_o = 1'b0;
        io_bus.Busy_o      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                io_bus.In_ready_o = 1'b1;
                if (io_bus.In_valid_i) begin
                    w_accept     = 1'b1;
                    w_next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                io_bus.Busy_o = 1'b1;
                if (w_last) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                io_bus.Busy_o      = 1'b1;
                io_bus.Out_valid_o = 1'b1;
                if (io_bus.Out_ready_i) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    assign w_pix     = r_pixels[r_idx*DATA_W +: DATA_W];
    assign w_coef    = r_coefs[r_idx*DATA_W +: DATA_W];
    assign w_sign    = r_signs[r_idx];
    assign w_acc_sel = w_sign ? r_acc_neg : r_acc_pos;

    Mac #(
        .MULT_SIZE  (DATA_W),
        .ACCUM_SIZE (ACC_W)
    ) u_mac (
        .Mult1_i  (w_pix),
        .Mult2_i  (w_coef),
        .Accum_i  (w_acc_sel),
        .Result_o (w_result)
    );

    // The accumulator is sized for nine full-scale products, so the carry is always zero.
    assign w_unused_carry = w_result[ACC_W];

    always_ff @(posedge Clk_i or negedge Rst_n_i) begin
        if (!Rst_n_i) begin
            r_pixels  <= '0;
            r_coefs   <= '0;
            r_signs   <= '0;
            r_acc_pos <= '0;
            r_acc_neg <= '0;
            r_idx     <= '0;
        end else if (w_accept) begin
            r_pixels  <= io_bus.Pixels_i;
            r_coefs   <= io_bus.Coefs_i;
            r_signs   <= io_bus.Signs_i;
            r_acc_pos <= '0;
            r_acc_neg <= '0;
            r_idx     <= '0;
        end else if (r_state == ST_RUN) begin
            if (w_sign) begin
                r_acc_neg <= w_result[ACC_W-1:0];
            end else begin
                r_acc_pos <= w_result[ACC_W-1:0];
            end
            if (!w_last) begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    assign w_magnitude = (r_acc_pos >= r_acc_neg) ? (r_acc_pos - r_acc_neg)
                                                  : (r_acc_neg - r_acc_pos);

    assign io_bus.Magnitude_o = w_magnitude;
    assign io_bus.Pixel_o     = (|w_magnitude[ACC_W-1:DATA_W]) ? {DATA_W{1'b1}}
                                                               : w_magnitude[DATA_W-1:0];

endmodule

// File: tb/tb_mac_kernel_sequencer.sv
// Directed self-checking bench for mac_kernel_sequencer (DATA_W = 8).
// Each scenario task drives its own window and checks hand-computed results.
module tb_mac_kernel_sequencer;

    localparam int DATA_W = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    mac_kernel_sequencer_if #(.DATA_W(DATA_W)) bus ();

    mac_kernel_sequencer #(.DATA_W(DATA_W)) dut (
        .Clk_i   (clk),
        .Rst_n_i (rst_n),
        .io_bus  (bus.slave)
    );

    // Presents a window and returns one cycle after the accept edge, valid dropped.
    task automatic send_window(input logic [71:0] pix, input logic [71:0] coef,
                               input logic [8:0] sgn);
        int n;
        n = 0;
        bus.Pixels_i   = pix;
        bus.Coefs_i    = coef;
        bus.Signs_i    = sgn;
        bus.In_valid_i = 1'b1;
        while (bus.In_ready_o !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n >= 40) begin
            failures++;
            $display("[TB] FAIL accept_timeout: In_ready_o=%b required 1", bus.In_ready_o);
        end
        @(posedge clk); #1;
        bus.In_valid_i = 1'b0;
    endtask

    task automatic wait_valid(output int cycles);
        cycles = 0;
        while (bus.Out_valid_o !== 1'b1 && cycles < 40) begin
            @(posedge clk); #1;
            cycles++;
        end
        if (bus.Out_valid_o !== 1'b1) cycles = -1;
    endtask

    task automatic test_reset();
        bus.In_valid_i  = 1'b0;
        bus.Out_ready_i = 1'b1;
        bus.Pixels_i    = '0;
        bus.Coefs_i     = '0;
        bus.Signs_i     = '0;
        #3;
        checks++;
        if (bus.In_ready_o !== 1'b1 || bus.Out_valid_o !== 1'b0 || bus.Busy_o !== 1'b0 ||
            bus.Magnitude_o !== 20'd0 || bus.Pixel_o !== 8'd0) begin
            failures++;
            $display("[TB] FAIL reset_values: rdy=%b vld=%b busy=%b mag=%0d pix=%0d required 1 0 0 0 0",
                     bus.In_ready_o, bus.Out_valid_o, bus.Busy_o, bus.Magnitude_o, bus.Pixel_o);
        end
        #19 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_flat_sum();
        int cyc;
        bus.Out_ready_i = 1'b1;
        send_window({9{8'd10}}, {9{8'd1}}, 9'b0);
        wait_valid(cyc);
        checks++;
        if (cyc !== 9) begin
            failures++;
            $display("[TB] FAIL flat_latency: got %0d cycles required 9", cyc);
        end
        checks++;
        if (bus.Magnitude_o !== 20'd90 || bus.Pixel_o !== 8'd90) begin
            failures++;
            $display("[TB] FAIL flat_value: mag=%0d pix=%0d required 90 90", bus.Magnitude_o, bus.Pixel_o);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.In_ready_o !== 1'b1 || bus.Out_valid_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL flat_return_idle: rdy=%b vld=%b required 1 0", bus.In_ready_o, bus.Out_valid_o);
        end
    endtask

    task automatic test_sobel_edge();
        int cyc;
        send_window({8'd255, 8'd255, 8'd0, 8'd255, 8'd255, 8'd0, 8'd255, 8'd255, 8'd0},
                    {8'd1, 8'd0, 8'd1, 8'd2, 8'd0, 8'd2, 8'd1, 8'd0, 8'd1}, 9'b001001001);
        wait_valid(cyc);
        checks++;
        if (cyc !== 9 || bus.Magnitude_o !== 20'd1020 || bus.Pixel_o !== 8'd255) begin
            failures++;
            $display("[TB] FAIL sobel_edge: cyc=%0d mag=%0d pix=%0d required 9 1020 255",
                     cyc, bus.Magnitude_o, bus.Pixel_o);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_sobel_flat();
        int cyc;
        send_window({9{8'd100}}, {8'd1, 8'd0, 8'd1, 8'd2, 8'd0, 8'd2, 8'd1, 8'd0, 8'd1}, 9'b001001001);
        wait_valid(cyc);
        checks++;
        if (cyc !== 9 || bus.Magnitude_o !== 20'd0 || bus.Pixel_o !== 8'd0) begin
            failures++;
            $display("[TB] FAIL sobel_flat: cyc=%0d mag=%0d pix=%0d required 9 0 0",
                     cyc, bus.Magnitude_o, bus.Pixel_o);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_full_scale();
        int cyc;
        send_window({9{8'd255}}, {9{8'd255}}, 9'b0);
        wait_valid(cyc);
        checks++;
        if (cyc !== 9 || bus.Magnitude_o !== 20'd585225 || bus.Pixel_o !== 8'd255) begin
            failures++;
            $display("[TB] FAIL full_scale_pos: cyc=%0d mag=%0d pix=%0d required 9 585225 255",
                     cyc, bus.Magnitude_o, bus.Pixel_o);
        end
        @(posedge clk); #1;
        send_window({9{8'd255}}, {9{8'd255}}, 9'h1FF);
        wait_valid(cyc);
        checks++;
        if (cyc !== 9 || bus.Magnitude_o !== 20'd585225 || bus.Pixel_o !== 8'd255) begin
            failures++;
            $display("[TB] FAIL full_scale_neg: cyc=%0d mag=%0d pix=%0d required 9 585225 255",
                     cyc, bus.Magnitude_o, bus.Pixel_o);
        end
        @(posedge clk); #1;
    endtask

    // Pixels 1..9, unit coefficients, taps 4..8 subtracted: |10 - 35| = 25.
    task automatic test_mixed_sign();
        int cyc;
        logic [71:0] p;
        for (int k = 0; k < 9; k++) p[k*8 +: 8] = 8'(k + 1);
        send_window(p, {9{8'd1}}, 9'b111110000);
        wait_valid(cyc);
        checks++;
        if (cyc !== 9 || bus.Magnitude_o !== 20'd25 || bus.Pixel_o !== 8'd25) begin
            failures++;
            $display("[TB] FAIL mixed_sign: cyc=%0d mag=%0d pix=%0d required 9 25 25",
                     cyc, bus.Magnitude_o, bus.Pixel_o);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        int cyc;
        bus.Out_ready_i = 1'b0;
        send_window({9{8'd10}}, {9{8'd1}}, 9'b0);
        wait_valid(cyc);
        checks++;
        if (cyc !== 9) begin
            failures++;
            $display("[TB] FAIL bp_latency: got %0d cycles required 9", cyc);
        end
        for (int i = 0; i < 5; i++) begin
            bus.In_valid_i = i[0];
            bus.Pixels_i   = {9{8'd200}};
            @(posedge clk); #1;
            checks++;
            if (bus.Out_valid_o !== 1'b1 || bus.In_ready_o !== 1'b0 || bus.Busy_o !== 1'b1 ||
                bus.Magnitude_o !== 20'd90 || bus.Pixel_o !== 8'd90) begin
                failures++;
                $display("[TB] FAIL bp_hold_%0d: vld=%b rdy=%b busy=%b mag=%0d pix=%0d required 1 0 1 90 90",
                         i, bus.Out_valid_o, bus.In_ready_o, bus.Busy_o, bus.Magnitude_o, bus.Pixel_o);
            end
        end
        bus.In_valid_i  = 1'b0;
        bus.Out_ready_i = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus.In_ready_o !== 1'b1 || bus.Out_valid_o !== 1'b0 || bus.Busy_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL bp_release: rdy=%b vld=%b busy=%b required 1 0 0",
                     bus.In_ready_o, bus.Out_valid_o, bus.Busy_o);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.Busy_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL bp_no_accept: busy=%b required 0", bus.Busy_o);
        end
    endtask

    // Valid held high through DONE: the second window waits for the IDLE cycle.
    task automatic test_back_to_back();
        int cyc;
        bus.Out_ready_i = 1'b1;
        send_window({9{8'd10}}, {9{8'd1}}, 9'b0);
        bus.In_valid_i = 1'b1;
        wait_valid(cyc);
        checks++;
        if (cyc !== 9) begin
            failures++;
            $display("[TB] FAIL b2b_first_latency: got %0d cycles required 9", cyc);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.In_ready_o !== 1'b1 || bus.Busy_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL b2b_idle_gap: rdy=%b busy=%b required 1 0", bus.In_ready_o, bus.Busy_o);
        end
        @(posedge clk); #1;
        bus.In_valid_i = 1'b0;
        checks++;
        if (bus.Busy_o !== 1'b1) begin
            failures++;
            $display("[TB] FAIL b2b_second_accept: busy=%b required 1", bus.Busy_o);
        end
        wait_valid(cyc);
        checks++;
        if (cyc !== 9 || bus.Magnitude_o !== 20'd90) begin
            failures++;
            $display("[TB] FAIL b2b_second_result: cyc=%0d mag=%0d required 9 90", cyc, bus.Magnitude_o);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_run();
        int cyc;
        bus.Out_ready_i = 1'b1;
        send_window({9{8'd10}}, {9{8'd1}}, 9'b0);
        repeat (4) begin
            @(posedge clk); #1;
        end
        checks++;
        if (bus.Busy_o !== 1'b1 || bus.Magnitude_o !== 20'd40) begin
            failures++;
            $display("[TB] FAIL mid_run_partial: busy=%b mag=%0d required 1 40", bus.Busy_o, bus.Magnitude_o);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.In_ready_o !== 1'b1 || bus.Out_valid_o !== 1'b0 || bus.Busy_o !== 1'b0 ||
            bus.Magnitude_o !== 20'd0 || bus.Pixel_o !== 8'd0) begin
            failures++;
            $display("[TB] FAIL mid_run_reset: rdy=%b vld=%b busy=%b mag=%0d pix=%0d required 1 0 0 0 0",
                     bus.In_ready_o, bus.Out_valid_o, bus.Busy_o, bus.Magnitude_o, bus.Pixel_o);
        end
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        send_window({9{8'd10}}, {9{8'd1}}, 9'b0);
        wait_valid(cyc);
        checks++;
        if (cyc !== 9 || bus.Magnitude_o !== 20'd90 || bus.Pixel_o !== 8'd90) begin
            failures++;
            $display("[TB] FAIL after_reset_flat: cyc=%0d mag=%0d pix=%0d required 9 90 90",
                     cyc, bus.Magnitude_o, bus.Pixel_o);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_flat_sum();
        test_sobel_edge();
        test_sobel_flat();
        test_full_scale();
        test_mixed_sign();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
